// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions: WB control bit positions,
// the hardwired-zero register index and default widths.
package wb_regfile_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_CNT_W   = 32;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int REG_ZERO    = 0;

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural register storage: sync reset, one write port,
// two async read ports (clk, rst, we, wa, wd, ra1, ra2 -> rd1, rd2).
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wa != ZERO_IDX) begin
      regs[wa] <= wd;
    end
  end

  // r0 is masked on read so it never depends on storage
  assign rd1 = (ra1 == ZERO_IDX) ? '0 : regs[ra1];
  assign rd2 = (ra2 == ZERO_IDX) ? '0 : regs[ra2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MemtoReg mux, register file with write bypass
// to the ID read ports, and a saturating retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_wb,
  input  logic [1:0]        WB_in,
  input  logic [DATA_W-1:0] RD_in,
  input  logic [DATA_W-1:0] ADDR_in,
  input  logic [REG_AW-1:0] WN_in,
  input  logic [REG_AW-1:0] RA1,
  input  logic [REG_AW-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WD_out,
  output logic              WE_out,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] core_rd1;
  logic [DATA_W-1:0] core_rd2;

  assign WD_out = WB_in[WB_MEMTOREG] ? RD_in : ADDR_in;

  // rst gates the strobe so reset always beats a pending write
  assign WE_out = WB_in[WB_REGWRITE] & en_wb
                & (WN_in != ZERO_IDX) & ~rst;

  regfile_core #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .we  (WE_out),
    .wa  (WN_in),
    .wd  (WD_out),
    .ra1 (RA1),
    .ra2 (RA2),
    .rd1 (core_rd1),
    .rd2 (core_rd2)
  );

  // WE_out implies WN_in != 0, so the bypass never hits r0
  assign RD1 = (WE_out && RA1 == WN_in) ? WD_out : core_rd1;
  assign RD2 = (WE_out && RA2 == WN_in) ? WD_out : core_rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count <= '0;
    end else if (WE_out && wb_count != '1) begin
      wb_count <= wb_count + 1'b1;
    end
  end

endmodule
